// File: rtl/tetris_timing_pkg.sv
// Shared timing types and helpers for the Tetris game core's rate-divider consumers.
package tetris_timing_pkg;

   typedef enum logic [1:0] {IDLE, FALLING, LOCKING, WAIT_LOCK} drop_state_t;

   function automatic int unsigned period_width(input int unsigned max_div,
                                                input int unsigned level_w);
      return $clog2(max_div + 1) + level_w + 1;
   endfunction

   localparam int unsigned PERIOD_W = period_width(48, 4);

   // Ticks per drop for a level; a level deep enough to go negative saturates at min_div.
   function automatic int drop_period(input int level,
                                      input int max_div = 48,
                                      input int step    = 4,
                                      input int min_div = 2);
      int p;
      p = max_div - level * step;
      return (p < min_div) ? min_div : p;
   endfunction

endpackage

// File: rtl/tick_rise_detect.sv
// Registered rising-edge detector for a synchronous square-wave tick.
module tick_rise_detect (
   input  logic ClockIn,
   input  logic resetn,
   input  logic In,
   output logic Rise
);

   logic tick_q;

   always_ff @(posedge ClockIn or negedge resetn) begin
      if (!resetn) tick_q <= 1'b0;
      else         tick_q <= In;
   end

   assign Rise = In & ~tick_q;

endmodule

// File: rtl/drop_timer.sv
// Gravity and lock-delay timer: turns rate-divider ticks into drop and lock requests.
// Optional feature: DROP_TIMER_LOCK_RESET_EN lets player moves reload the lock delay.
module drop_timer
   import tetris_timing_pkg::*;
#(
   parameter int unsigned MAX_DIV    = 48,
   parameter int unsigned STEP       = 4,
   parameter int unsigned MIN_DIV    = 2,
   parameter int unsigned SOFT_DIV   = 2,
   parameter int unsigned LOCK_TICKS = 30,
   parameter int unsigned LEVEL_W    = 4,
   parameter int unsigned MAX_RESETS = 15
) (
   input  logic               ClockIn,
   input  logic               resetn,
   input  logic               TickIn,
   input  logic               Run,
   input  logic               Pause,
   input  logic [LEVEL_W-1:0] Level,
   input  logic               SoftDrop,
   input  logic               Grounded,
   input  logic               Move,
   output logic               DropReq,
   input  logic               DropAck,
   output logic               LockReq,
   input  logic               LockAck
);

   localparam int unsigned CNT_W  = $clog2(MAX_DIV + 1);
   localparam int unsigned LOCK_W = $clog2(LOCK_TICKS + 1);
   localparam logic [CNT_W-1:0]  SOFT_LAST = CNT_W'(SOFT_DIV - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TICKS - 1);

   logic              tick_raw, tick;
   logic [CNT_W-1:0]  frame_cnt, period_m1, eff;
   logic [LOCK_W-1:0] lock_cnt;
   drop_state_t       state;

   tick_rise_detect u_tick (
      .ClockIn (ClockIn),
      .resetn  (resetn),
      .In      (TickIn),
      .Rise    (tick_raw)
   );

   assign tick = tick_raw & ~Pause;

   always_comb begin
      period_m1 = CNT_W'(drop_period(int'(Level), int'(MAX_DIV), int'(STEP), int'(MIN_DIV)) - 1);
      eff       = (SoftDrop && (frame_cnt > SOFT_LAST)) ? SOFT_LAST : frame_cnt;
   end

`ifdef DROP_TIMER_LOCK_RESET_EN
   logic [3:0] reset_cnt;
   logic       move_reload;
   assign move_reload = Move && (reset_cnt < 4'(MAX_RESETS));
`else
   logic unused_move;
   assign unused_move = Move;
`endif

   always_ff @(posedge ClockIn or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         frame_cnt <= '0;
         lock_cnt  <= '0;
         DropReq   <= 1'b0;
         LockReq   <= 1'b0;
`ifdef DROP_TIMER_LOCK_RESET_EN
         reset_cnt <= '0;
`endif
      end else if (!Run) begin
         state   <= IDLE;
         DropReq <= 1'b0;
         LockReq <= 1'b0;
      end else begin
         // Ack clears first so a newly due request in the same cycle wins.
         if (DropAck) DropReq <= 1'b0;
         if (LockAck) LockReq <= 1'b0;
         case (state)
            IDLE: begin
               state     <= FALLING;
               frame_cnt <= period_m1;
`ifdef DROP_TIMER_LOCK_RESET_EN
               reset_cnt <= '0;
`endif
            end
            FALLING: begin
               if (Grounded) begin
                  state    <= LOCKING;
                  lock_cnt <= LOCK_LAST;
               end else if (tick) begin
                  if (eff == '0) begin
                     DropReq   <= 1'b1;
                     frame_cnt <= period_m1;
                  end else begin
                     frame_cnt <= eff - 1'b1;
                  end
               end
            end
            LOCKING: begin
               if (!Grounded) begin
                  state     <= FALLING;
                  frame_cnt <= period_m1;
`ifdef DROP_TIMER_LOCK_RESET_EN
               end else if (move_reload) begin
                  lock_cnt  <= LOCK_LAST;
                  reset_cnt <= reset_cnt + 1'b1;
`endif
               end else if (tick) begin
                  if (lock_cnt == '0) begin
                     LockReq <= 1'b1;
                     state   <= WAIT_LOCK;
                  end else begin
                     lock_cnt <= lock_cnt - 1'b1;
                  end
               end
            end
            WAIT_LOCK: begin
               if (LockAck) begin
                  state     <= FALLING;
                  frame_cnt <= period_m1;
`ifdef DROP_TIMER_LOCK_RESET_EN
                  reset_cnt <= '0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_drop_timer.sv
// Directed self-checking bench for drop_timer (honours DROP_TIMER_LOCK_RESET_EN).
module tb_drop_timer;

   logic       ClockIn = 1'b0;
   logic       resetn, TickIn, Run, Pause, SoftDrop, Grounded, Move, DropAck, LockAck;
   logic [3:0] Level;
   logic       DropReq, LockReq;

   int tests = 0;
   int fails = 0;
   int n;

   typedef struct {
      int level;
      int first;
      int second;
   } vec_t;

   vec_t vecs[7];

   always #5 ClockIn = ~ClockIn;

   drop_timer dut (
      .ClockIn  (ClockIn),
      .resetn   (resetn),
      .TickIn   (TickIn),
      .Run      (Run),
      .Pause    (Pause),
      .Level    (Level),
      .SoftDrop (SoftDrop),
      .Grounded (Grounded),
      .Move     (Move),
      .DropReq  (DropReq),
      .DropAck  (DropAck),
      .LockReq  (LockReq),
      .LockAck  (LockAck)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge ClockIn) TickIn = 1'b1;
      @(negedge ClockIn) TickIn = 1'b0;
   endtask

   // Returns the index of the tick on which DropReq is seen, 0 if none within maxn.
   task automatic wait_drop(input int maxn, output int cnt);
      cnt = 0;
      for (int i = 1; i <= maxn; i++) begin
         do_tick();
         if (DropReq) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic wait_lock(input int maxn, output int cnt);
      cnt = 0;
      for (int i = 1; i <= maxn; i++) begin
         do_tick();
         if (LockReq) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic restart(input int lvl);
      @(negedge ClockIn) begin Run = 1'b0; Level = 4'(lvl); end
      @(negedge ClockIn) Run = 1'b1;
      @(negedge ClockIn);
   endtask

   task automatic pulse_move();
      @(negedge ClockIn) Move = 1'b1;
      @(negedge ClockIn) Move = 1'b0;
   endtask

   task automatic pulse_lock_ack();
      @(negedge ClockIn) LockAck = 1'b1;
      @(negedge ClockIn) LockAck = 1'b0;
   endtask

   task automatic pulse_drop_ack();
      @(negedge ClockIn) DropAck = 1'b1;
      @(negedge ClockIn) DropAck = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{level: 0,  first: 48, second: 48};
      vecs[1] = '{level: 1,  first: 44, second: 44};
      vecs[2] = '{level: 5,  first: 28, second: 28};
      vecs[3] = '{level: 10, first: 8,  second: 8};
      vecs[4] = '{level: 11, first: 4,  second: 4};
      vecs[5] = '{level: 12, first: 2,  second: 2};
      vecs[6] = '{level: 15, first: 2,  second: 2};

      resetn = 1'b0; TickIn = 1'b0; Run = 1'b0; Pause = 1'b0; SoftDrop = 1'b0;
      Grounded = 1'b0; Move = 1'b0; DropAck = 1'b1; LockAck = 1'b0; Level = '0;
      #1;
      check("reset_dropreq", int'(DropReq), 0);
      check("reset_lockreq", int'(LockReq), 0);
      @(negedge ClockIn);
      @(negedge ClockIn) resetn = 1'b1;

      foreach (vecs[i]) begin
         restart(vecs[i].level);
         wait_drop(120, n);
         check($sformatf("lvl%0d_first", vecs[i].level), n, vecs[i].first);
         wait_drop(120, n);
         check($sformatf("lvl%0d_second", vecs[i].level), n, vecs[i].second);
      end

      // Level change mid-count only takes effect at the next reload.
      restart(0);
      wait_drop(10, n);
      check("lvlchg_none", n, 0);
      Level = 4'd15;
      wait_drop(60, n);
      check("lvlchg_first", n, 38);
      wait_drop(60, n);
      check("lvlchg_second", n, 2);

      // Soft drop with frame_cnt at 20.
      restart(0);
      wait_drop(27, n);
      check("soft_none", n, 0);
      SoftDrop = 1'b1;
      do_tick();
      check("soft_tick1", int'(DropReq), 0);
      do_tick();
      check("soft_tick2", int'(DropReq), 1);
      SoftDrop = 1'b0;
      wait_drop(60, n);
      check("soft_after", n, 48);

      // Lock delay, request held until ack, then a fresh fall period.
      DropAck = 1'b0;
      restart(0);
      Grounded = 1'b1;
      @(negedge ClockIn);
      wait_lock(40, n);
      check("lock_tick", n, 30);
      check("lock_nodrop", int'(DropReq), 0);
      repeat (3) do_tick();
      check("lock_held", int'(LockReq), 1);
      Grounded = 1'b0;
      pulse_lock_ack();
      check("lock_ack_clear", int'(LockReq), 0);
      wait_drop(60, n);
      check("lock_newpiece", n, 48);
      pulse_drop_ack();
      DropAck = 1'b1;

      // Lifting off the stack at lock tick 10 returns to falling without a lock.
      restart(0);
      Grounded = 1'b1;
      @(negedge ClockIn);
      repeat (10) do_tick();
      Grounded = 1'b0;
      @(negedge ClockIn);
      wait_drop(60, n);
      check("unground_drop", n, 48);
      check("unground_nolock", int'(LockReq), 0);

      // Drops coalesce while the ack is withheld.
      DropAck = 1'b0;
      restart(15);
      wait_drop(4, n);
      check("coal_first", n, 2);
      repeat (2) do_tick();
      check("coal_held", int'(DropReq), 1);
      pulse_drop_ack();
      check("coal_ack_clear", int'(DropReq), 0);
      do_tick();
      check("coal_noqueue", int'(DropReq), 0);
      do_tick();
      check("coal_next", int'(DropReq), 1);
      pulse_drop_ack();
      DropAck = 1'b1;

      // Pause freezes the count.
      restart(0);
      wait_drop(20, n);
      check("pause_pre", n, 0);
      Pause = 1'b1;
      wait_drop(100, n);
      check("pause_during", n, 0);
      Pause = 1'b0;
      wait_drop(60, n);
      check("pause_resume", n, 28);

      // Run low drops pending requests.
      DropAck = 1'b0;
      restart(15);
      wait_drop(4, n);
      check("runlow_pend", n, 2);
      @(negedge ClockIn) Run = 1'b0;
      @(negedge ClockIn);
      check("runlow_clear", int'(DropReq), 0);

      // Asynchronous reset in the middle of locking.
      restart(15);
      wait_drop(4, n);
      check("rst_pend", n, 2);
      Grounded = 1'b1;
      @(negedge ClockIn);
      repeat (5) do_tick();
      resetn = 1'b0;
      #1;
      check("rst_dropreq", int'(DropReq), 0);
      check("rst_lockreq", int'(LockReq), 0);
      Grounded = 1'b0;
      @(negedge ClockIn) resetn = 1'b1;
      @(negedge ClockIn);
      wait_drop(10, n);
      check("rst_restart", n, 2);
      pulse_drop_ack();
      DropAck = 1'b1;

      // Move at lock tick 20; with the reset feature it reloads the lock delay.
      restart(0);
      Grounded = 1'b1;
      @(negedge ClockIn);
      wait_lock(20, n);
      check("move_pre", n, 0);
      pulse_move();
      wait_lock(40, n);
`ifdef DROP_TIMER_LOCK_RESET_EN
      check("move_delay", n, 30);
`else
      check("move_delay", n, 10);
`endif
      pulse_lock_ack();
      @(negedge ClockIn);
      repeat (15) pulse_move();
      wait_lock(20, n);
      check("move16_pre", n, 0);
      pulse_move();
      wait_lock(40, n);
      check("move16_ignored", n, 10);
      Grounded = 1'b0;
      pulse_lock_ack();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/drop_timer.md
# drop_timer

Gravity and lock-delay timer for the Tetris game core. Consumes the square-wave tick produced by the upstream rate divider (configured at the frame rate, e.g. 60 Hz) and converts it into level-dependent one-piece-down requests and a lock request once the active piece has rested on the stack long enough. Sits between the rate divider and the piece/board controller, handshaking with the latter.

## Interface
- MAX_DIV, 48: ticks per drop at level 0
- STEP, 4: ticks removed per level
- MIN_DIV, 2: floor on ticks per drop
- SOFT_DIV, 2: ticks per drop while SoftDrop held
- LOCK_TICKS, 30: ticks grounded before lock
- LEVEL_W, 4: width of Level
- MAX_RESETS, 15: lock-timer reload limit (macro feature only)

- ClockIn  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- TickIn  in  1  rate-divider output, square wave, synchronous to ClockIn
- Run  in  1  game active; low forces IDLE
- Pause  in  1  freeze all counters
- Level  in  LEVEL_W  current game level
- SoftDrop  in  1  player soft-drop held
- Grounded  in  1  active piece cannot move down
- Move  in  1  one-cycle pulse, successful player move/rotate
- DropReq  out  1  move piece down one row; held until DropAck
- DropAck  in  1  controller accepted drop
- LockReq  out  1  lock piece; held until LockAck
- LockAck  in  1  controller locked piece and spawned next

## Operation
- Tick = rising edge of TickIn: tick_q register (reset 0); tick = TickIn & ~tick_q. Ticks ignored while Pause high.
- period = max(MAX_DIV − Level·STEP, MIN_DIV), computed signed at width $clog2(MAX_DIV+1)+LEVEL_W+1; sampled only on frame_cnt reload.
- States: IDLE, FALLING, LOCKING, WAIT_LOCK.
- IDLE: Run high → FALLING, frame_cnt ← period−1.
- FALLING, tick, Grounded low: eff = SoftDrop ? min(frame_cnt, SOFT_DIV−1) : frame_cnt; eff==0 → DropReq ← 1, frame_cnt ← period−1; else frame_cnt ← eff−1.
- FALLING, Grounded high (any cycle) → LOCKING, lock_cnt ← LOCK_TICKS−1; no drops issued in LOCKING.
- LOCKING: tick decrements lock_cnt; tick at lock_cnt==0 → LockReq ← 1, WAIT_LOCK. Grounded low → FALLING, frame_cnt ← period−1.
- WAIT_LOCK: LockAck → FALLING, frame_cnt ← period−1 (new piece).
- DropReq pending when another drop is due: coalesced, not queued; frame_cnt reloads normally.
- DropReq/LockReq cleared at the edge after the cycle their Ack is sampled high.
- Run low in any state: IDLE, DropReq, LockReq cleared next edge.
- Level changes mid-count take effect at next reload; Level large enough for negative period saturates at MIN_DIV.

## Timing
- Reset: state IDLE, DropReq 0, LockReq 0, tick_q 0, counters 0.
- DropReq rises on the same edge that samples the due TickIn rising edge (one-cycle latency from TickIn).
- Grounded-to-LOCKING: one edge. Ack-to-deassert: one edge.
- Pause does not clear pending requests; handshakes proceed while paused.

## Configuration
- DROP_TIMER_LOCK_RESET_EN defined: Move pulse in LOCKING reloads lock_cnt ← LOCK_TICKS−1, at most MAX_RESETS times per piece (4-bit reset_cnt cleared on entering FALLING from WAIT_LOCK/IDLE); further Moves ignored.
- Undefined: Move ignored, no reset_cnt logic.

## Structure
- Package tetris_timing_pkg: drop_state_t enum, period width localparam, function drop_period(level) with saturation.
- Sub-module tick_rise_detect: registered rising-edge detector (ClockIn, resetn, In, Rise), reusable for other rate-divider consumers.

## Test plan
- Level 0, Run high, DropAck tied high: first DropReq on 48th TickIn rise, then every 48 rises.
- Level 5 → DropReq every 28 rises; Level 15 → every 2 rises (MIN_DIV).
- Level 0, SoftDrop asserted with frame_cnt=20: next tick frame_cnt=0, DropReq on following tick.
- Grounded high: LockReq on 30th tick; Grounded low at tick 10 instead → FALLING, no LockReq; LockAck → new period count.
- DropAck withheld across two due points → single DropReq, no queued second; Pause high 100 ticks → counters unchanged.
- resetn low mid-LOCKING → DropReq=LockReq=0, IDLE; with macro, Move at lock tick 20 delays LockReq by 20 ticks, 16th Move ignored.
